// File: rtl/logic_sweep_pkg.sv
// logic_sweep_pkg: golden-function codes, FSM states and mode legality for the sweep checker
package logic_sweep_pkg;
  typedef enum logic [2:0] {
    MODE_NOR  = 3'd0,
    MODE_NAND = 3'd1,
    MODE_AND  = 3'd2,
    MODE_OR   = 3'd3,
    MODE_XOR  = 3'd4
  } mode_e;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_e;
  function automatic logic mode_is_legal(input logic [2:0] m);
    return m <= MODE_XOR;
  endfunction
endpackage

// File: rtl/logic_sweep_checker_if.sv
// logic_sweep_checker_if: control, stimulus and result signals between a lab bench and the sweep checker
interface logic_sweep_checker_if #(parameter int N_IN = 2);
  logic            start;
  logic [2:0]      mode;
  logic [N_IN-1:0] stim;
  logic            dut_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] first_fail;
  logic            first_fail_vld;
  modport master (
    output start, mode, dut_out,
    input  stim, busy, done, pass, err_count, first_fail, first_fail_vld
  );
  modport slave (
    input  start, mode, dut_out,
    output stim, busy, done, pass, err_count, first_fail, first_fail_vld
  );
endinterface

// File: rtl/sweep_golden.sv
// sweep_golden: reference reduction of the current vector for the selected mode
module sweep_golden import logic_sweep_pkg::*; #(
  parameter int N_IN = 2
) (
  input  logic [2:0]      mode,
  input  logic [N_IN-1:0] vec,
  output logic            exp
);
  // reserved codes never reach here mid-sweep; they map to 0
  always_comb
    exp = mode == MODE_NOR  ? ~|vec :
          mode == MODE_NAND ? ~&vec :
          mode == MODE_AND  ? &vec  :
          mode == MODE_OR   ? |vec  :
          mode == MODE_XOR  ? ^vec  : 1'b0;
endmodule

// File: rtl/logic_sweep_checker.sv
// logic_sweep_checker: exhaustive truth-table sweep of an external DUT against a golden function
module logic_sweep_checker import logic_sweep_pkg::*; #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 4
) (
  input logic                clk,
  input logic                rst_n,
  logic_sweep_checker_if.slave bus
);
  localparam int WW = $clog2(SETTLE + 1);
  state_e          state, state_n;
  logic [2:0]      mode_q;
  logic [WW-1:0]   wait_cnt;
  logic            exp, mis, accept, last, settled;
  logic [N_IN:0]   err_n;
  sweep_golden #(.N_IN(N_IN)) u_golden (.mode(mode_q), .vec(bus.stim), .exp(exp));
  // start acceptance, sample comparison and next state; X/Z on dut_out counts as a mismatch
  always_comb begin
    accept  = (state == S_IDLE || state == S_DONE) && bus.start && mode_is_legal(bus.mode);
    mis     = bus.dut_out !== exp;
    err_n   = bus.err_count + {{N_IN{1'b0}}, mis};
    last    = &bus.stim;
    settled = wait_cnt == WW'(SETTLE - 1);
    state_n = accept                      ? S_WAIT  :
              state == S_WAIT && settled  ? S_CHECK :
              state == S_CHECK            ? (last ? S_DONE : S_WAIT) : state;
  end
  // state register
  always_ff @(posedge clk)
    state <= !rst_n ? S_IDLE : state_n;
  // stimulus, settle counter and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q             <= MODE_NOR;
      wait_cnt           <= '0;
      bus.stim           <= '0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.pass           <= 1'b0;
      bus.err_count      <= '0;
      bus.first_fail     <= '0;
      bus.first_fail_vld <= 1'b0;
    end else if (accept) begin
      mode_q             <= bus.mode;
      wait_cnt           <= '0;
      bus.stim           <= '0;
      bus.busy           <= 1'b1;
      bus.done           <= 1'b0;
      bus.pass           <= 1'b0;
      bus.err_count      <= '0;
      bus.first_fail     <= '0;
      bus.first_fail_vld <= 1'b0;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt + WW'(1);
    end else if (state == S_CHECK) begin
      bus.err_count <= err_n;
      if (mis && !bus.first_fail_vld) begin
        bus.first_fail     <= bus.stim;
        bus.first_fail_vld <= 1'b1;
      end
      if (last) begin
        bus.busy <= 1'b0;
        bus.done <= 1'b1;
        bus.pass <= err_n == '0;
      end else begin
        bus.stim <= bus.stim + N_IN'(1);
        wait_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_logic_sweep_checker.sv
// tb_logic_sweep_checker: directed sweeps on three checker instances with a result scoreboard
module tb_logic_sweep_checker;
  import logic_sweep_pkg::*;
  typedef struct {
    string tag;
    int    lat;
    int    err;
    int    ff;
    int    vld;
    int    pass;
    int    last;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   acc = 0;
  int   total = 0;
  int   bad = 0;
  int   sel24 = 0;
  int   sel3 = 0;
  exp_t sb[$];
  logic p1 = 1'b1, p2 = 1'b1, p3 = 1'b0, p4 = 1'b1;
  logic q1 = 1'b1, q2 = 1'b1, q3 = 1'b0, q4 = 1'b1;
  logic_sweep_checker_if #(.N_IN(2)) b24 ();
  logic_sweep_checker_if #(.N_IN(2)) b21 ();
  logic_sweep_checker_if #(.N_IN(3)) b3 ();
  logic_sweep_checker #(.N_IN(2), .SETTLE(4)) u24 (.clk(clk), .rst_n(rst_n), .bus(b24));
  logic_sweep_checker #(.N_IN(2), .SETTLE(1)) u21 (.clk(clk), .rst_n(rst_n), .bus(b21));
  logic_sweep_checker #(.N_IN(3), .SETTLE(4)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // NOR built from four NANDs, 10 time units per gate
  always @(b24.stim) begin
    p1 <= #10 ~(b24.stim[0] & b24.stim[0]);
    p2 <= #10 ~(b24.stim[1] & b24.stim[1]);
  end
  always @(p1 or p2) p3 <= #10 ~(p1 & p2);
  always @(p3) p4 <= #10 ~(p3 & p3);
  always @(b21.stim) begin
    q1 <= #10 ~(b21.stim[0] & b21.stim[0]);
    q2 <= #10 ~(b21.stim[1] & b21.stim[1]);
  end
  always @(q1 or q2) q3 <= #10 ~(q1 & q2);
  always @(q3) q4 <= #10 ~(q3 & q3);
  assign b24.dut_out = sel24 == 0 ? ~|b24.stim : sel24 == 1 ? p4 : 1'b1;
  assign b21.dut_out = q4;
  assign b3.dut_out  = sel3 == 0 ? 1'b0 : sel3 == 1 ? 1'b1 : ~&b3.stim;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask
  task automatic peek(input int k, output logic [31:0] st, bz, dn, ps, er, ff, vl);
    case (k)
      0: begin
        st = 32'(b24.stim); bz = 32'(b24.busy); dn = 32'(b24.done); ps = 32'(b24.pass);
        er = 32'(b24.err_count); ff = 32'(b24.first_fail); vl = 32'(b24.first_fail_vld);
      end
      1: begin
        st = 32'(b21.stim); bz = 32'(b21.busy); dn = 32'(b21.done); ps = 32'(b21.pass);
        er = 32'(b21.err_count); ff = 32'(b21.first_fail); vl = 32'(b21.first_fail_vld);
      end
      default: begin
        st = 32'(b3.stim); bz = 32'(b3.busy); dn = 32'(b3.done); ps = 32'(b3.pass);
        er = 32'(b3.err_count); ff = 32'(b3.first_fail); vl = 32'(b3.first_fail_vld);
      end
    endcase
  endtask
  task automatic start_only(input int k, input logic [2:0] m);
    @(negedge clk);
    case (k)
      0: begin b24.mode = m; b24.start = 1'b1; end
      1: begin b21.mode = m; b21.start = 1'b1; end
      default: begin b3.mode = m; b3.start = 1'b1; end
    endcase
    @(posedge clk);
    #1;
    acc = cyc;
    b24.start = 1'b0;
    b21.start = 1'b0;
    b3.start  = 1'b0;
  endtask
  task automatic go(input int k, input logic [2:0] m, input exp_t e);
    sb.push_back(e);
    start_only(k, m);
  endtask
  task automatic finish_sweep(input int k);
    exp_t e;
    logic [31:0] st, bz, dn, ps, er, ff, vl;
    peek(k, st, bz, dn, ps, er, ff, vl);
    while (dn !== 32'd1 && cyc - acc < 400) begin
      @(posedge clk);
      #1;
      peek(k, st, bz, dn, ps, er, ff, vl);
    end
    e = sb.pop_front();
    chk({e.tag, ".latency"}, 32'(cyc - acc), 32'(e.lat));
    chk({e.tag, ".done"}, dn, 32'd1);
    chk({e.tag, ".busy"}, bz, 32'd0);
    chk({e.tag, ".err_count"}, er, 32'(e.err));
    chk({e.tag, ".first_fail"}, ff, 32'(e.ff));
    chk({e.tag, ".first_fail_vld"}, vl, 32'(e.vld));
    chk({e.tag, ".pass"}, ps, 32'(e.pass));
    chk({e.tag, ".stim_end"}, st, 32'(e.last));
  endtask
  initial begin
    logic [31:0] st, bz, dn, ps, er, ff, vl;
    rst_n = 1'b0;
    b24.start = 1'b1; b24.mode = MODE_NOR;
    b21.start = 1'b1; b21.mode = MODE_NOR;
    b3.start  = 1'b1; b3.mode  = MODE_AND;
    repeat (3) @(posedge clk);
    #1;
    peek(0, st, bz, dn, ps, er, ff, vl);
    chk("reset.stim", st, 0);
    chk("reset.busy", bz, 0);
    chk("reset.done", dn, 0);
    chk("reset.pass", ps, 0);
    chk("reset.err_count", er, 0);
    chk("reset.first_fail", ff, 0);
    chk("reset.first_fail_vld", vl, 0);
    peek(2, st, bz, dn, ps, er, ff, vl);
    chk("reset.n3_busy", bz, 0);
    @(negedge clk);
    rst_n = 1'b1;
    b24.start = 1'b0;
    b21.start = 1'b0;
    b3.start  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    peek(0, st, bz, dn, ps, er, ff, vl);
    chk("post_reset.busy", bz, 0);
    sel24 = 0;
    go(0, MODE_NOR, '{"nor_ideal", 20, 0, 0, 0, 1, 3});
    finish_sweep(0);
    sel24 = 1;
    go(0, MODE_NOR, '{"nor_nand_s4", 20, 0, 0, 0, 1, 3});
    finish_sweep(0);
    go(1, MODE_NOR, '{"nor_nand_s1", 8, 1, 1, 1, 0, 3});
    finish_sweep(1);
    sel3 = 0;
    go(2, MODE_AND, '{"and_stuck0", 40, 1, 7, 1, 0, 7});
    finish_sweep(2);
    sel3 = 1;
    go(2, MODE_AND, '{"and_stuck1", 40, 7, 0, 1, 0, 7});
    finish_sweep(2);
    sel3 = 2;
    go(2, MODE_NAND, '{"nand_midstart", 40, 0, 0, 0, 1, 7});
    repeat (7) @(posedge clk);
    #1;
    b3.mode  = MODE_OR;
    b3.start = 1'b1;
    @(posedge clk);
    #1;
    b3.start = 1'b0;
    peek(2, st, bz, dn, ps, er, ff, vl);
    chk("midstart.busy", bz, 1);
    finish_sweep(2);
    sel24 = 2;
    start_only(0, MODE_NOR);
    repeat (11) @(posedge clk);
    #1;
    peek(0, st, bz, dn, ps, er, ff, vl);
    chk("rst_mid.stim_before", st, 2);
    chk("rst_mid.err_before", er, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    peek(0, st, bz, dn, ps, er, ff, vl);
    chk("rst_mid.stim", st, 0);
    chk("rst_mid.busy", bz, 0);
    chk("rst_mid.err_count", er, 0);
    chk("rst_mid.first_fail_vld", vl, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    b24.mode  = 3'd6;
    b24.start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    peek(0, st, bz, dn, ps, er, ff, vl);
    chk("reserved.busy", bz, 0);
    chk("reserved.done", dn, 0);
    @(negedge clk);
    b24.start = 1'b0;
    go(0, MODE_NOR, '{"nor_after_rst", 20, 3, 1, 1, 0, 3});
    finish_sweep(0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
